// File: rtl/asip_pkg.sv
// asip_pkg: constants and FSM state type shared by the data-memory responder
// and its lane storage.
//   WORD_W - width of one processor data word
//   LANE_W - width of one storage lane
//   LANES  - lanes per word (WORD_W = LANES * LANE_W)
//   ADDR_W - width of the word address taken from the ALU result
//   state_t - responder FSM states
package asip_pkg;

    localparam int WORD_W = 48;
    localparam int LANE_W = 16;
    localparam int LANES  = 3;
    localparam int ADDR_W = 16;

    // IDLE  : accepting a request (req_ready = 1)
    // LANEk : accessing storage lane k of the latched word
    // RESP  : one-cycle response strobe
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LANE0 = 3'd1,
        LANE1 = 3'd2,
        LANE2 = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/dmem_responder_lane_ram.sv
// lane_ram: single-port lane storage, WORDS x LANE_W.
// Synchronous write on the rising clock edge, combinational read at the same
// address. Contents are never cleared.
// Ports:
//   clk   - clock
//   we    - write enable for this cycle
//   addr  - lane index
//   wdata - lane write data
//   rdata - lane read data (combinational from addr)
module lane_ram #(
    parameter int WORDS  = 768,
    parameter int LANE_W = 16,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-stage data responder for a 48-bit processor.
// A word is stored as three 16-bit lanes in a single-port lane RAM, so each
// request walks IDLE -> LANE0 -> LANE1 -> LANE2 -> RESP -> IDLE, touching one
// lane per cycle. The pipeline is stalled while the walk is in progress.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE. The response is a single
// rsp_valid pulse four cycles after acceptance, carrying rsp_rdata/rsp_err;
// there is no backpressure on the response side.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   req_valid     - request present
//   req_write     - 1 = write, 0 = read
//   req_addr      - word address
//   req_wdata     - write data
//   req_ready     - idle and accepting
//   stall         - ~req_ready
//   rsp_valid     - one-cycle response strobe
//   rsp_rdata     - read data (0 for writes and errors), held until next RESP
//   rsp_err       - address out of range, valid with rsp_valid
//   dbg_state     - current FSM state encoding
module dmem_responder #(
    parameter int DEPTH  = 256,
    parameter int LANE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [15:0]         req_addr,
    input  logic [3*LANE_W-1:0] req_wdata,
    output logic                req_ready,
    output logic                stall,
    output logic                rsp_valid,
    output logic [3*LANE_W-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic [2:0]          dbg_state
);

    import asip_pkg::*;

    localparam int          WW        = LANES * LANE_W;
    localparam int          RAM_WORDS = 3 * DEPTH;
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [17:0] RAM_LIMIT = 18'(RAM_WORDS);

    state_t state_q, state_d;

    // Latched request
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WW-1:0]     wdata_q;
    logic              inrng_q;

    // Lanes 0 and 1 of a read, waiting for lane 2
    logic [2*LANE_W-1:0] asm_q;

    // Lane access
    logic [1:0]        lane_sel;
    logic              lane_active;
    logic [17:0]       idx;
    logic              lane_ok;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [LANE_W-1:0] ram_wdata;
    logic [LANE_W-1:0] ram_rdata;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = LANE0;
            LANE0:   state_d = LANE1;
            LANE1:   state_d = LANE2;
            LANE2:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign stall     = ~req_ready;
    assign rsp_valid = (state_q == RESP);
    assign dbg_state = state_q;

    // ---------------- Lane addressing ----------------
    always_comb begin
        lane_sel    = 2'd0;
        lane_active = 1'b0;
        case (state_q)
            LANE0: begin lane_sel = 2'd0; lane_active = 1'b1; end
            LANE1: begin lane_sel = 2'd1; lane_active = 1'b1; end
            LANE2: begin lane_sel = 2'd2; lane_active = 1'b1; end
            default: begin lane_sel = 2'd0; lane_active = 1'b0; end
        endcase
    end

    // 3*addr+k at full 18-bit width; 3*0xFFFF+2 still fits.
    assign idx = 18'(addr_q) * 18'd3 + 18'(lane_sel);

    // The index bound is redundant with inrng_q but keeps the RAM address
    // provably in range if DEPTH is not a power of two.
    assign lane_ok  = inrng_q && lane_active && (idx < RAM_LIMIT);
    // Reset in the same cycle as a lane write suppresses it, so an aborted
    // write stops at the lanes already committed.
    assign ram_we   = lane_ok && wr_q && !rst;
    assign ram_addr = lane_ok ? idx[AW-1:0] : '0;

    always_comb begin
        ram_wdata = wdata_q[LANE_W-1:0];
        case (lane_sel)
            2'd1:    ram_wdata = wdata_q[2*LANE_W-1:LANE_W];
            2'd2:    ram_wdata = wdata_q[3*LANE_W-1:2*LANE_W];
            default: ram_wdata = wdata_q[LANE_W-1:0];
        endcase
    end

    lane_ram #(
        .WORDS  (RAM_WORDS),
        .LANE_W (LANE_W),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // ---------------- Request latch, assembly, response ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            inrng_q   <= 1'b0;
            asm_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        inrng_q <= (32'(req_addr) < DEPTH);
                    end
                end
                LANE0: asm_q[LANE_W-1:0]        <= ram_rdata;
                LANE1: asm_q[2*LANE_W-1:LANE_W] <= ram_rdata;
                LANE2: begin
                    // Lane 2 goes straight into the response register.
                    rsp_rdata <= (wr_q || !inrng_q) ? '0 : {ram_rdata, asm_q};
                    rsp_err   <= !inrng_q;
                end
                default: ;
            endcase
        end
    end

endmodule
